seq_div: RTL
============

// Module: seq_div
// PURPOSE
//  - Multi-cycle restoring divider; the inverse of the team's sequential multiplier.
//  - Takes an 11-bit product-width dividend and an 8-bit divisor.
//  - Returns quotient and remainder using the same start/valid handshake as the multiplier.
//  - Used in the asynctest design set to round-trip multiplier results.
// PARAMETERS
//  DW  11  dividend and quotient width (bits); also the iteration count
//  VW  8   divisor and remainder width (bits)
// PORTS
//  clk        in   1   rising-edge clock
//  rst        in   1   synchronous reset, active-high
//  dividend   in   DW  numerator, sampled on accepted start
//  divisor    in   VW  denominator, sampled on accepted start
//  start      in   1   request; accepted only when start && valid
//  valid      out  1   high = idle, result stable; low = busy
//  quotient   out  DW  registered quotient
//  remainder  out  VW  registered remainder
//  dz         out  1   divide-by-zero flag (present only with SEQ_DIV_DZ_FLAG_EN)
// BEHAVIOUR
//  - Interface: one clock (clk); reset rst is synchronous, active-high.
//  - Reset: at any clk edge with rst=1, the block aborts any operation.
//    - valid=1, quotient=0, remainder=0, dz=0; iteration counter=0.
//    - rst has priority over start.
//  - States: IDLE (valid=1) and BUSY (valid=0); valid is a registered state bit.
//  - IDLE->BUSY on an edge with start && valid:
//    - latch dividend into shift reg N, divisor into D, clear partial remainder P (VW+1 bits).
//    - load counter = DW.
//  - BUSY, each edge: restoring step, MSB-first.
//    - T = {P[VW-1:0], N[DW-1]}.
//    - if T >= {1'b0,D}: P = T - D, shift 1 into N LSB; else P = T, shift 0 into N LSB.
//    - counter decrements.
//  - BUSY->IDLE on the edge where counter reaches 0; on that edge quotient=N and remainder=P[VW-1:0].
//  - Latency: valid is low for exactly DW cycles after the accepting edge, then rises with results valid.
//  - quotient, remainder and dz hold their previous values throughout BUSY.
//  - They change only on the completion edge or on reset.
//  - start while BUSY is ignored: no effect, no queuing.
//  - start high on the completion cycle is not accepted; it is accepted the next cycle, with valid=1.
//  - Back-to-back throughput: one division per DW+1 cycles.
//  - Divisor = 0: the full DW cycles still run.
//    - Result: quotient = all ones (2^DW-1), remainder = dividend[VW-1:0] (truncated).
//  - Divisor 1: quotient = dividend, remainder = 0.
//  - dividend < divisor: quotient = 0, remainder = dividend.
//  - Arithmetic is unsigned throughout; no overflow is possible since quotient width = DW.
// CONFIGURATION
//  SEQ_DIV_DZ_FLAG_EN defined:
//    - port dz exists.
//    - dz is set on the completion edge iff latched divisor == 0, else cleared.
//    - dz holds with the results.
//  SEQ_DIV_DZ_FLAG_EN undefined:
//    - no dz port and no flag register.
//    - quotient/remainder and timing are identical.
// TESTING
//  1  reset: rst=1 for 2 cycles -> valid=1, quotient=0, remainder=0, dz=0
//  2  dividend=200, divisor=7, start 1 cycle
//     -> valid low exactly 11 cycles, then quotient=28, remainder=4
//  3  round-trip: 37*3=111; dividend=111, divisor=37 -> quotient=3, remainder=0
//     also 2047/255 -> q=8, r=7; 5/9 -> q=0, r=5
//  4  dividend=100, divisor=0
//     -> after 11 cycles quotient=2047, remainder=100; dz=1 with macro
//     next op 10/2 -> q=5, r=0, dz=0
//  5  start held high continuously while busy, inputs changed mid-op
//     -> the first operands' result is unaffected
//     -> next op accepted only on the first cycle valid=1
//  6  rst=1 at cycle 5 of a 200/7 division -> valid=1, outputs 0 next edge
//     fresh 9/3 then yields q=3, r=0

Source files
------------

// File: rtl/seq_div.sv
// ============================================================================
// Module      : seq_div
// Description : Multi-cycle unsigned restoring divider (DW-bit dividend,
//               VW-bit divisor), one quotient bit per clock, MSB first.
//               Optional divide-by-zero flag port dz under SEQ_DIV_DZ_FLAG_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_div #(
    parameter int DW = 11,
    parameter int VW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    input  logic          start,
    output logic          valid,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder
`ifdef SEQ_DIV_DZ_FLAG_EN
    ,
    output logic          dz
`endif
);

    localparam int CW = $clog2(DW + 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] n_q, n_d;
    logic [VW-1:0] d_q, d_d;
    // Only the low VW bits of the partial remainder are ever consumed,
    // so the top bit of the (VW+1)-bit value is not stored.
    logic [VW-1:0] p_q, p_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] quo_q, quo_d;
    logic [VW-1:0] rem_q, rem_d;
    logic [VW:0]   w_trial;
    logic [VW:0]   w_diff;
    logic          w_ge;
`ifdef SEQ_DIV_DZ_FLAG_EN
    logic          dz_q, dz_d;
`endif

    assign w_trial = {p_q, n_q[DW-1]};
    assign w_ge    = (w_trial >= {1'b0, d_q});
    assign w_diff  = w_trial - {1'b0, d_q};

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        d_d     = d_q;
        p_d     = p_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
`ifdef SEQ_DIV_DZ_FLAG_EN
        dz_d    = dz_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_BUSY;
                    n_d     = dividend;
                    d_d     = divisor;
                    p_d     = '0;
                    cnt_d   = CW'(DW);
                end
            end
            S_BUSY: begin
                p_d   = w_ge ? w_diff[VW-1:0] : w_trial[VW-1:0];
                n_d   = {n_q[DW-2:0], w_ge};
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = S_IDLE;
                    quo_d   = n_d;
                    rem_d   = p_d;
`ifdef SEQ_DIV_DZ_FLAG_EN
                    dz_d    = (d_q == '0);
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            n_q     <= '0;
            d_q     <= '0;
            p_q     <= '0;
            cnt_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
`ifdef SEQ_DIV_DZ_FLAG_EN
            dz_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            d_q     <= d_d;
            p_q     <= p_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
`ifdef SEQ_DIV_DZ_FLAG_EN
            dz_q    <= dz_d;
`endif
        end
    end

    assign valid     = (state_q == S_IDLE);
    assign quotient  = quo_q;
    assign remainder = rem_q;
`ifdef SEQ_DIV_DZ_FLAG_EN
    assign dz        = dz_q;
`endif

endmodule

`default_nettype wire
